// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp from the
// sysid slave, latches both words and flags pass / mismatch / timeout.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h4E71_BFC3,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE, ERROR
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT_LAST = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
  localparam bit          NO_LAT   = (READ_LATENCY == 0);

  state_t      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [1:0]  lat_q, lat_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        match_q, match_d;
  logic        auto_q;
  logic        start_eff;

  // The pending auto-start makes the first edge after reset act like start=1.
  assign start_eff = start | auto_q;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    lat_d   = lat_q;
    id_d    = id_q;
    ts_d    = ts_q;
    match_d = match_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_eff) begin
          state_d = RD_ID;
          match_d = 1'b0;
          tmo_d   = '0;
          lat_d   = '0;
        end
      end

      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          tmo_d = '0;
          lat_d = '0;
          if (!NO_LAT) begin
            state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
          end else if (state_q == RD_ID) begin
            id_d    = avm_readdata;
            state_d = RD_TS;
          end else begin
            ts_d    = avm_readdata;
            match_d = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
            state_d = DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = ERROR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      LAT_ID: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          id_d    = avm_readdata;
          state_d = RD_TS;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      LAT_TS: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          ts_d    = avm_readdata;
          match_d = (id_q == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
          state_d = DONE;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the async reset clears results as well as control.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      lat_q   <= '0;
      id_q    <= '0;
      ts_q    <= '0;
      match_q <= 1'b0;
      auto_q  <= AUTO_START;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      lat_q   <= lat_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      match_q <= match_d;
      auto_q  <= 1'b0;
    end
  end

  // Bus strobes are decoded from the state register, so reset drops them at once.
  assign avm_read        = (state_q == RD_ID) || (state_q == RD_TS);
  assign avm_address     = (state_q == RD_TS) || (state_q == LAT_TS);
  assign busy            = (state_q == RD_ID) || (state_q == LAT_ID) ||
                           (state_q == RD_TS) || (state_q == LAT_TS);
  assign done            = (state_q == DONE);
  assign timeout_err     = (state_q == ERROR);
  assign match           = match_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: three checker instances (zero latency auto-start, short
// timeout without auto-start, two-cycle read latency) against small slave models.
module tb_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'h4E71_BFC3;
  localparam logic [31:0] ID2    = 32'h1234_5678;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // u0: defaults, combinational slave with controllable timestamp and stalls
  logic        start0, wr0, addr0, rd0, busy0, done0, match0, tmo0;
  logic [31:0] rdata0, id0, ts0, slave_ts0;
  assign rdata0 = addr0 ? slave_ts0 : 32'h0;

  sysid_checker u0 (
    .clock(clock), .reset(reset), .start(start0),
    .avm_address(addr0), .avm_read(rd0), .avm_waitrequest(wr0), .avm_readdata(rdata0),
    .id_value(id0), .timestamp_value(ts0),
    .busy(busy0), .done(done0), .match(match0), .timeout_err(tmo0)
  );

  // u1: short timeout, no auto-start
  logic        start1, wr1, addr1, rd1, busy1, done1, match1, tmo1;
  logic [31:0] rdata1, id1, ts1;
  assign rdata1 = addr1 ? EXP_TS : 32'h0;

  sysid_checker #(.TIMEOUT_CYCLES(8), .AUTO_START(1'b0)) u1 (
    .clock(clock), .reset(reset), .start(start1),
    .avm_address(addr1), .avm_read(rd1), .avm_waitrequest(wr1), .avm_readdata(rdata1),
    .id_value(id1), .timestamp_value(ts1),
    .busy(busy1), .done(done1), .match(match1), .timeout_err(tmo1)
  );

  // u2: two-cycle latency slave, data valid only on the capture cycle
  logic        start2, wr2, addr2, rd2, busy2, done2, match2, tmo2;
  logic [31:0] rdata2, id2, ts2;
  logic        v0, a0, v1, a1;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      v0 <= 1'b0; a0 <= 1'b0; v1 <= 1'b0; a1 <= 1'b0;
    end else begin
      v0 <= rd2 && !wr2;
      a0 <= addr2;
      v1 <= v0;
      a1 <= a0;
    end
  end
  assign rdata2 = v1 ? (a1 ? EXP_TS : ID2) : 32'hDEAD_BEEF;

  sysid_checker #(.EXPECTED_ID(ID2), .READ_LATENCY(2), .AUTO_START(1'b0)) u2 (
    .clock(clock), .reset(reset), .start(start2),
    .avm_address(addr2), .avm_read(rd2), .avm_waitrequest(wr2), .avm_readdata(rdata2),
    .id_value(id2), .timestamp_value(ts2),
    .busy(busy2), .done(done2), .match(match2), .timeout_err(tmo2)
  );

  // Runs one check on u0 with `stalls` waitrequest cycles on the timestamp read.
  task automatic run0(input int stalls, output int edges, output int ts_reads);
    int left;
    left     = stalls;
    edges    = 0;
    ts_reads = 0;
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    while (!done0 && !tmo0 && edges < 50) begin
      if (rd0 && addr0) ts_reads++;
      wr0 = rd0 && addr0 && (left > 0);
      if (wr0) left--;
      @(negedge clock);
      edges++;
    end
    wr0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges, reads;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
    slave_ts0 = EXP_TS;

    #12;
    check("rst_read",  {31'b0, rd0},   32'd0);
    check("rst_addr",  {31'b0, addr0}, 32'd0);
    check("rst_busy",  {31'b0, busy0}, 32'd0);
    check("rst_done",  {31'b0, done0}, 32'd0);
    check("rst_match", {31'b0, match0}, 32'd0);
    check("rst_tmo",   {31'b0, tmo0},  32'd0);
    check("rst_id",    id0, 32'd0);
    check("rst_ts",    ts0, 32'd0);

    // Auto-start after reset release on a zero-wait slave.
    @(negedge clock);
    reset = 1'b0;
    reads = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (rd0) reads++;
      if (i == 1) check("auto_busy", {31'b0, busy0}, 32'd1);
      if (i == 2) check("auto_done_early", {31'b0, done0}, 32'd0);
      if (i == 3) check("auto_done", {31'b0, done0}, 32'd1);
    end
    check("auto_reads", reads, 32'd2);
    check("auto_match", {31'b0, match0}, 32'd1);
    check("auto_id", id0, 32'd0);
    check("auto_ts", ts0, EXP_TS);
    check("noauto_u1_busy", {31'b0, busy1}, 32'd0);
    check("noauto_u1_done", {31'b0, done1}, 32'd0);

    // Wrong timestamp from the slave.
    slave_ts0 = 32'h4E71_BFC4;
    run0(0, edges, reads);
    check("bad_edges", edges, 32'd2);
    check("bad_done",  {31'b0, done0},  32'd1);
    check("bad_match", {31'b0, match0}, 32'd0);
    check("bad_tmo",   {31'b0, tmo0},   32'd0);
    check("bad_ts",    ts0, 32'h4E71_BFC4);

    // Five stall cycles on the timestamp read.
    slave_ts0 = EXP_TS;
    run0(5, edges, reads);
    check("stall_edges", edges, 32'd7);
    check("stall_ts_hold", reads, 32'd6);
    check("stall_match", {31'b0, match0}, 32'd1);

    // Stuck waitrequest on u1 trips the timeout after 8 stall edges.
    wr1 = 1'b1;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    edges = 0;
    while (!tmo1 && edges < 40) begin
      @(negedge clock);
      edges++;
    end
    check("tmo_edges", edges, 32'd8);
    check("tmo_err",   {31'b0, tmo1},  32'd1);
    check("tmo_busy",  {31'b0, busy1}, 32'd0);
    check("tmo_read",  {31'b0, rd1},   32'd0);
    check("tmo_done",  {31'b0, done1}, 32'd0);
    check("tmo_match", {31'b0, match1}, 32'd0);

    // Recovery with a healthy slave.
    wr1 = 1'b0;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    edges = 0;
    while (!done1 && edges < 40) begin
      @(negedge clock);
      edges++;
    end
    check("rec_edges", edges, 32'd2);
    check("rec_match", {31'b0, match1}, 32'd1);
    check("rec_tmo",   {31'b0, tmo1},   32'd0);

    // Two-cycle latency on u2 with start pulses while busy.
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    edges = 0;
    reads = 1;
    while (!done2 && edges < 40) begin
      start2 = (edges == 1) || (edges == 3);
      @(negedge clock);
      edges++;
      if (rd2) reads++;
    end
    start2 = 1'b0;
    check("lat_edges", edges, 32'd6);
    check("lat_id",    id2, ID2);
    check("lat_ts",    ts2, EXP_TS);
    check("lat_match", {31'b0, match2}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (rd2) reads++;
    end
    check("lat_reads", reads, 32'd2);
    check("lat_done_hold", {31'b0, done2}, 32'd1);

    // Reset in the middle of a stalled timestamp read.
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    @(negedge clock);
    wr0 = 1'b1;
    @(negedge clock);
    check("mid_read", {31'b0, rd0}, 32'd1);
    check("mid_addr", {31'b0, addr0}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_read",  {31'b0, rd0},   32'd0);
    check("mid_rst_addr",  {31'b0, addr0}, 32'd0);
    check("mid_rst_busy",  {31'b0, busy0}, 32'd0);
    check("mid_rst_match", {31'b0, match0}, 32'd0);
    check("mid_rst_id",    id0, 32'd0);
    check("mid_rst_ts",    ts0, 32'd0);
    check("mid_rst_u2_done", {31'b0, done2}, 32'd0);
    wr0 = 1'b0;

    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clock);
    check("idle_u1_read", {31'b0, rd1},   32'd0);
    check("idle_u1_busy", {31'b0, busy1}, 32'd0);
    check("idle_u0_done", {31'b0, done0}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
